// File: rtl/convert_float_to_radicand_if.sv
// Operand/result bundle between the sqrt front-end and its requester.
interface convert_float_to_radicand_if #(
   parameter int unsigned BINARY_SIZE   = 106,
   parameter int unsigned EXPONENT_SIZE = 11
);
   logic                     en;
   logic                     is_float;
   logic [63:0]              operand;
   logic [BINARY_SIZE-1:0]   binary;
   logic [EXPONENT_SIZE-1:0] result_exponent;
   logic                     is_exponent_odd;
   logic                     is_zero;
   logic                     is_inf;
   logic                     is_nan;
   logic                     busy;
   logic                     is_done;

   modport master (
      output en, is_float, operand,
      input  binary, result_exponent, is_exponent_odd, is_zero, is_inf, is_nan, busy, is_done
   );

   modport slave (
      input  en, is_float, operand,
      output binary, result_exponent, is_exponent_odd, is_zero, is_inf, is_nan, busy, is_done
   );
endinterface

// File: rtl/convert_float_to_radicand.sv
// Sqrt front-end: unpacks an IEEE single/double, classifies it and aligns the radicand.
// Define SUBNORM_NORMALIZE_EN to normalize subnormals instead of flushing them to zero.
module convert_float_to_radicand #(
   parameter int unsigned BINARY_SIZE   = 106,
   parameter int unsigned EXPONENT_SIZE = 11,
   parameter int unsigned DOUBLE_BIAS   = 1023,
   parameter int unsigned SINGLE_BIAS   = 127
) (
   input logic                        clk,
   input logic                        rst,
   convert_float_to_radicand_if.slave bus_io
);

   localparam int unsigned ExpW = EXPONENT_SIZE + 2;

   typedef enum logic [2:0] {
      StIdle,
      StUnpack,
      StAlign,
      StDone
`ifdef SUBNORM_NORMALIZE_EN
      , StNorm
`endif
   } state_e;

   state_e                   state_q;
   logic [63:0]              op_q;
   logic                     float_q;
   logic signed [ExpW-1:0]   e_q;
   logic [52:0]              m_q;
   logic [BINARY_SIZE-1:0]   binary_q;
   logic [EXPONENT_SIZE-1:0] res_exp_q;
   logic                     odd_q;
   logic                     zero_q;
   logic                     inf_q;
   logic                     nan_q;
   logic                     busy_q;
   logic                     done_q;

   // Field extraction; the fraction is top-aligned so bit 52 of m_q is always the hidden bit.
   logic                   sign;
   logic [10:0]            exp_field;
   logic [51:0]            frac;
   logic                   exp_max;
   logic                   exp_zero;
   logic                   frac_zero;
   logic signed [ExpW-1:0] bias;
   logic signed [ExpW-1:0] e_norm;

   always_comb begin
      if (float_q) begin
         sign      = op_q[31];
         exp_field = {3'b000, op_q[30:23]};
         frac      = {op_q[22:0], 29'd0};
         exp_max   = (op_q[30:23] == 8'hFF);
         bias      = $signed(ExpW'(SINGLE_BIAS));
      end else begin
         sign      = op_q[63];
         exp_field = op_q[62:52];
         frac      = op_q[51:0];
         exp_max   = (op_q[62:52] == 11'h7FF);
         bias      = $signed(ExpW'(DOUBLE_BIAS));
      end
      exp_zero  = (exp_field == 11'd0);
      frac_zero = (frac == 52'd0);
      e_norm    = $signed(ExpW'(exp_field)) - bias;
   end

`ifdef SUBNORM_NORMALIZE_EN
   logic signed [ExpW-1:0] e_sub;
   assign e_sub = $signed(ExpW'(1)) - bias;
`endif

   // Halved exponent: the odd case borrows one so the shift is exact.
   logic                   odd;
   logic signed [ExpW-1:0] e_adj;
   logic signed [ExpW-1:0] e_half;
   logic signed [ExpW-1:0] r_exp;
   logic [23:0]            m24;
   logic [BINARY_SIZE-1:0] bin_next;

   always_comb begin
      odd      = e_q[0];
      e_adj    = e_q - $signed(ExpW'(odd));
      e_half   = e_adj >>> 1;
      r_exp    = e_half + bias;
      m24      = m_q[52:29];
      bin_next = '0;
      if (float_q) begin
         if (odd) bin_next[24 +: 24] = m24;
         else     bin_next[23 +: 24] = m24;
      end else begin
         if (odd) bin_next[53 +: 53] = m_q;
         else     bin_next[52 +: 53] = m_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= '0;
         float_q   <= 1'b0;
         e_q       <= '0;
         m_q       <= '0;
         binary_q  <= '0;
         res_exp_q <= '0;
         odd_q     <= 1'b0;
         zero_q    <= 1'b0;
         inf_q     <= 1'b0;
         nan_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus_io.en) begin
                  op_q    <= bus_io.operand;
                  float_q <= bus_io.is_float;
                  odd_q   <= 1'b0;
                  zero_q  <= 1'b0;
                  inf_q   <= 1'b0;
                  nan_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StUnpack;
               end
            end
            StUnpack: begin
               state_q <= StAlign;
               if (exp_max) begin
                  if (!frac_zero || sign) nan_q <= 1'b1;
                  else                    inf_q <= 1'b1;
               end else if (exp_zero && frac_zero) begin
                  zero_q <= 1'b1;
               end else if (sign) begin
                  nan_q <= 1'b1;
               end else if (exp_zero) begin
`ifdef SUBNORM_NORMALIZE_EN
                  m_q     <= {1'b0, frac};
                  e_q     <= e_sub;
                  state_q <= StNorm;
`else
                  zero_q <= 1'b1;
`endif
               end else begin
                  m_q <= {1'b1, frac};
                  e_q <= e_norm;
               end
            end
`ifdef SUBNORM_NORMALIZE_EN
            StNorm: begin
               m_q <= m_q << 1;
               e_q <= e_q - $signed(ExpW'(1));
               if (m_q[51]) state_q <= StAlign;
            end
`endif
            StAlign: begin
               if (zero_q || inf_q || nan_q) begin
                  binary_q  <= '0;
                  res_exp_q <= '0;
                  odd_q     <= 1'b0;
               end else begin
                  binary_q  <= bin_next;
                  res_exp_q <= EXPONENT_SIZE'(r_exp);
                  odd_q     <= odd;
               end
               state_q <= StDone;
            end
            StDone: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.binary          = binary_q;
   assign bus_io.result_exponent = res_exp_q;
   assign bus_io.is_exponent_odd = odd_q;
   assign bus_io.is_zero         = zero_q;
   assign bus_io.is_inf          = inf_q;
   assign bus_io.is_nan          = nan_q;
   assign bus_io.busy            = busy_q;
   assign bus_io.is_done         = done_q;

endmodule

// File: tb/tb_convert_float_to_radicand.sv
// Directed bench for convert_float_to_radicand with a queue of expected results.
module tb_convert_float_to_radicand;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   convert_float_to_radicand_if bus ();

   convert_float_to_radicand dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   typedef struct {
      logic [105:0] bin;
      logic [10:0]  rexp;
      logic         odd;
      logic         chk_odd;
      logic         zero;
      logic         inf;
      logic         nan;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   function automatic exp_t single_ok(input logic [23:0] m, input logic odd, input logic [10:0] r,
                                      input int lat);
      exp_t e;
      e.bin = '0;
      if (odd) e.bin[24 +: 24] = m;
      else     e.bin[23 +: 24] = m;
      e.rexp = r; e.odd = odd; e.chk_odd = 1'b1;
      e.zero = 1'b0; e.inf = 1'b0; e.nan = 1'b0; e.lat = lat;
      return e;
   endfunction

   function automatic exp_t double_ok(input logic [52:0] m, input logic odd, input logic [10:0] r);
      exp_t e;
      e.bin = '0;
      if (odd) e.bin[53 +: 53] = m;
      else     e.bin[52 +: 53] = m;
      e.rexp = r; e.odd = odd; e.chk_odd = 1'b1;
      e.zero = 1'b0; e.inf = 1'b0; e.nan = 1'b0; e.lat = 3;
      return e;
   endfunction

   function automatic exp_t flagged(input logic z, input logic i, input logic n);
      exp_t e;
      e.bin = '0; e.rexp = '0; e.odd = 1'b0; e.chk_odd = 1'b0;
      e.zero = z; e.inf = i; e.nan = n; e.lat = 3;
      return e;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_bin"},  128'(bus.binary), 128'd0);
      check({tag, "_rexp"}, 128'(bus.result_exponent), 128'd0);
      check({tag, "_odd"},  128'(bus.is_exponent_odd), 128'd0);
      check({tag, "_zero"}, 128'(bus.is_zero), 128'd0);
      check({tag, "_inf"},  128'(bus.is_inf), 128'd0);
      check({tag, "_nan"},  128'(bus.is_nan), 128'd0);
      check({tag, "_busy"}, 128'(bus.busy), 128'd0);
      check({tag, "_done"}, 128'(bus.is_done), 128'd0);
   endtask

   // Leaves the bench #1 after the accepting edge.
   task automatic launch(input logic f, input logic [63:0] op, input exp_t e);
      @(negedge clk);
      bus.en       = 1'b1;
      bus.is_float = f;
      bus.operand  = op;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      check("busy_after_accept", 128'(bus.busy), 128'd1);
   endtask

   task automatic wait_done(input string tag, input int already);
      int   cnt;
      exp_t e;
      cnt = already;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!bus.is_done && cnt < 100);
      check({tag, "_done"}, 128'(bus.is_done), 128'd1);
      e = sb.pop_front();
      check({tag, "_lat"},  128'(cnt), 128'(e.lat));
      check({tag, "_bin"},  128'(bus.binary), 128'(e.bin));
      check({tag, "_rexp"}, 128'(bus.result_exponent), 128'(e.rexp));
      if (e.chk_odd) check({tag, "_odd"}, 128'(bus.is_exponent_odd), 128'(e.odd));
      check({tag, "_zero"}, 128'(bus.is_zero), 128'(e.zero));
      check({tag, "_inf"},  128'(bus.is_inf), 128'(e.inf));
      check({tag, "_nan"},  128'(bus.is_nan), 128'(e.nan));
      check({tag, "_busy"}, 128'(bus.busy), 128'd0);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 128'(bus.is_done), 128'd0);
   endtask

   task automatic run(input string tag, input logic f, input logic [63:0] op, input exp_t e);
      launch(f, op, e);
      wait_done(tag, 0);
   endtask

   initial begin
      bus.en       = 1'b0;
      bus.is_float = 1'b0;
      bus.operand  = '0;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run("s4p0",   1'b1, 64'h40800000, single_ok(24'h800000, 1'b0, 11'd128, 3));
      run("s2p0",   1'b1, 64'h40000000, single_ok(24'h800000, 1'b1, 11'd127, 3));
      run("s0p5",   1'b1, 64'h3F000000, single_ok(24'h800000, 1'b1, 11'd126, 3));
      run("spi",    1'b1, 64'h40490FDB, single_ok(24'hC90FDB, 1'b1, 11'd127, 3));
      run("d1p0",   1'b0, 64'h3FF0000000000000, double_ok(53'h10000000000000, 1'b0, 11'd1023));
      run("d2p0",   1'b0, 64'h4000000000000000, double_ok(53'h10000000000000, 1'b1, 11'd1023));
      run("d0p25",  1'b0, 64'h3FD0000000000000, double_ok(53'h10000000000000, 1'b0, 11'd1022));
      run("dpi",    1'b0, 64'h400921FB54442D18, double_ok(53'h1921FB54442D18, 1'b1, 11'd1023));

      run("sneg1",  1'b1, 64'hBF800000, flagged(1'b0, 1'b0, 1'b1));
      run("sinf",   1'b1, 64'h7F800000, flagged(1'b0, 1'b1, 1'b0));
      run("sninf",  1'b1, 64'hFF800000, flagged(1'b0, 1'b0, 1'b1));
      run("snan",   1'b1, 64'h7FC00000, flagged(1'b0, 1'b0, 1'b1));
      run("snzero", 1'b1, 64'h80000000, flagged(1'b1, 1'b0, 1'b0));
      run("dnan",   1'b0, 64'h7FF8000000000000, flagged(1'b0, 1'b0, 1'b1));
      run("dinf",   1'b0, 64'h7FF0000000000000, flagged(1'b0, 1'b1, 1'b0));
      run("dnzero", 1'b0, 64'h8000000000000000, flagged(1'b1, 1'b0, 1'b0));
      run("dneg2",  1'b0, 64'hC000000000000000, flagged(1'b0, 1'b0, 1'b1));
      run("ssubneg", 1'b1, 64'h80000001, flagged(1'b0, 1'b0, 1'b1));
`ifdef SUBNORM_NORMALIZE_EN
      run("ssub",   1'b1, 64'h00000001, single_ok(24'h800000, 1'b1, 11'd52, 26));
`else
      run("ssub",   1'b1, 64'h00000001, flagged(1'b1, 1'b0, 1'b0));
`endif

      // en re-asserted while busy with other operands must be ignored.
      launch(1'b1, 64'h40800000, single_ok(24'h800000, 1'b0, 11'd128, 3));
      @(negedge clk);
      bus.en       = 1'b1;
      bus.is_float = 1'b0;
      bus.operand  = 64'h4000000000000000;
      @(posedge clk);
      #1;
      @(negedge clk);
      bus.is_float = 1'b1;
      bus.operand  = 64'h7F800000;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      wait_done("busy_en", 2);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("no_queue_busy", 128'(bus.busy), 128'd0);
      end

      // Reset while in ALIGN: outputs clear at once and the operation is dropped.
      @(negedge clk);
      bus.en       = 1'b1;
      bus.is_float = 1'b1;
      bus.operand  = 64'h40000000;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("mid_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         check("post_rst_done", 128'(bus.is_done), 128'd0);
      end
      run("after_rst", 1'b1, 64'h40000000, single_ok(24'h800000, 1'b1, 11'd127, 3));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
